// File: rtl/multi_seven_seg_driver.sv
// rtl/multi_seven_seg_driver.sv - multiplexed seven-segment driver with binary-to-decimal conversion
//
// Converts a binary value (unsigned or two's complement) to decimal with a
// sequential double-dabble engine and shows it on NUM_DIGITS multiplexed
// common-anode digits.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   data         value to display (DATA_W bits)
//   signed_mode  1: data is two's complement, 0: unsigned (sampled with load)
//   load         one-cycle request to convert and display data
//   seg          active-low segments, bit7 = dp, bits6..0 = g..a
//   an           active-low digit enables, bit0 = rightmost digit
//   busy         high while a conversion is in progress
//   ovf          last converted value did not fit in NUM_DIGITS
module multi_seven_seg_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 8,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     data,
  input  logic                  signed_mode,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  ovf
);

  // Enough BCD digits for any DATA_W-bit magnitude, and never fewer than the
  // display so every display digit has a BCD nibble behind it.
  localparam int BCD_MIN = (DATA_W + 2) / 3;
  localparam int BCD_N   = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
  localparam int BW      = 4 * BCD_N;
  localparam int PW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int CW      = $clog2(DATA_W);

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ZERO  = 8'hC0;

  typedef enum logic [1:0] {IDLE, CONVERT, FORMAT} state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [DATA_W-1:0]               mag_q, mag_d;
  logic [BW-1:0]                   bcd_q, bcd_d;
  logic                            sign_q, sign_d;
  logic [NUM_DIGITS-1:0][7:0]      disp_q, disp_d;
  logic                            ovf_q, ovf_d;
  logic [PW-1:0]                   presc_q, presc_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [NUM_DIGITS-1:0]           an_q, an_d;
  logic [7:0]                      seg_q, seg_d;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hF8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONVERT;
      CONVERT: if (cnt_q == CW'(DATA_W - 1)) state_d = FORMAT;
      FORMAT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q != IDLE);
  end

  // ---------------- conversion datapath ----------------
  always_comb begin
    logic [BW-1:0]        bcd_t;
    logic [BW+DATA_W-1:0] sh;
    int                   msd;
    int                   need;
    logic                 ovf_n;

    cnt_d  = cnt_q;
    mag_d  = mag_q;
    bcd_d  = bcd_q;
    sign_d = sign_q;
    disp_d = disp_q;
    ovf_d  = ovf_q;
    bcd_t  = bcd_q;
    sh     = '0;
    msd    = 0;
    need   = 0;
    ovf_n  = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          sign_d = signed_mode & data[DATA_W-1];
          // Negating the most-negative value wraps to itself, which read as
          // unsigned is exactly its magnitude.
          mag_d  = (signed_mode && data[DATA_W-1]) ? (~data + DATA_W'(1)) : data;
          bcd_d  = '0;
          cnt_d  = '0;
        end
      end
      CONVERT: begin
        // Add 3 to every nibble >= 5 before the shift so it carries correctly.
        for (int k = 0; k < BCD_N; k++) begin
          if (bcd_t[k*4 +: 4] >= 4'd5) bcd_t[k*4 +: 4] = bcd_t[k*4 +: 4] + 4'd3;
        end
        sh    = {bcd_t, mag_q} << 1;
        bcd_d = sh[BW+DATA_W-1:DATA_W];
        mag_d = sh[DATA_W-1:0];
        cnt_d = cnt_q + CW'(1);
      end
      FORMAT: begin
        for (int k = 0; k < BCD_N; k++) begin
          if (bcd_q[k*4 +: 4] != 4'd0) msd = k;
        end
        need  = msd + 1 + (sign_q ? 1 : 0);
        ovf_n = (need > NUM_DIGITS);
        ovf_d = ovf_n;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (ovf_n)                     disp_d[i] = SEG_DASH;
          else if (i <= msd)             disp_d[i] = seg_of(bcd_q[i*4 +: 4]);
          else if (sign_q && i == msd+1) disp_d[i] = SEG_DASH;
          else                           disp_d[i] = SEG_BLANK;
        end
      end
      default: ;
    endcase
  end

  // ---------------- scan datapath ----------------
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    // Registered from the next index so an/seg move on the edge that ends
    // the terminal count.
    an_d  = ~(NUM_DIGITS'(1) << idx_d);
    seg_d = disp_q[idx_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      mag_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      disp_q  <= {{(NUM_DIGITS-1){SEG_BLANK}}, SEG_ZERO};
      ovf_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= ~NUM_DIGITS'(1);
      seg_q   <= SEG_ZERO;
    end else begin
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_multi_seven_seg_driver.sv
// tb/tb_multi_seven_seg_driver.sv - scoreboard bench for multi_seven_seg_driver
module tb_multi_seven_seg_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'd0;
  logic       signed_mode = 1'b0;
  logic       load4 = 1'b0;
  logic       load2 = 1'b0;

  logic [7:0] seg4, seg2;
  logic [3:0] an4;
  logic [1:0] an2;
  logic       busy4, busy2, ovf4, ovf2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] disp;
    logic        ovf;
  } exp_t;

  exp_t sb4[$];
  exp_t sb2[$];

  always #5 clk = ~clk;

  multi_seven_seg_driver #(.NUM_DIGITS(4), .DATA_W(8), .SCAN_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .data(data), .signed_mode(signed_mode),
    .load(load4), .seg(seg4), .an(an4), .busy(busy4), .ovf(ovf4)
  );

  multi_seven_seg_driver #(.NUM_DIGITS(2), .DATA_W(8), .SCAN_DIV(4)) dut2 (
    .clk(clk), .reset(reset), .data(data), .signed_mode(signed_mode),
    .load(load2), .seg(seg2), .an(an2), .busy(busy2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic exp_t model(input logic [7:0] v, input logic sgn, input int nd);
    exp_t e;
    int   mag, n, tmp, p;
    logic neg;
    neg = sgn && v[7];
    mag = neg ? (256 - int'(v)) : int'(v);
    n   = 1;
    tmp = mag;
    while (tmp >= 10) begin tmp = tmp / 10; n++; end
    e.disp = '0;
    e.ovf  = ((n + (neg ? 1 : 0)) > nd);
    p = 1;
    for (int i = 0; i < nd; i++) begin
      if (e.ovf)                e.disp[i*8 +: 8] = 8'hBF;
      else if (i < n)           e.disp[i*8 +: 8] = pat((mag / p) % 10);
      else if (neg && i == n)   e.disp[i*8 +: 8] = 8'hBF;
      else                      e.disp[i*8 +: 8] = 8'hFF;
      p = p * 10;
    end
    return e;
  endfunction

  // Sample one full scan period and rebuild the display contents from an/seg.
  task automatic capture(input int which, output logic [31:0] got);
    logic [3:0] anv;
    logic [7:0] sv;
    got = '0;
    for (int k = 0; k < which * 4 + 1; k++) begin
      anv = (which == 4) ? an4 : {2'b11, an2};
      sv  = (which == 4) ? seg4 : seg2;
      for (int i = 0; i < which; i++) begin
        if (anv[i] == 1'b0) got[i*8 +: 8] = sv;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_load(input int which, input logic [7:0] v, input logic sgn,
                          input int relo_at, input string tag);
    int          cnt;
    logic        b;
    exp_t        e;
    logic [31:0] got;
    logic [31:0] mask;
    @(negedge clk);
    data = v;
    signed_mode = sgn;
    if (which == 4) begin load4 = 1'b1; sb4.push_back(model(v, sgn, 4)); end
    else            begin load2 = 1'b1; sb2.push_back(model(v, sgn, 2)); end
    @(negedge clk);
    load4 = 1'b0;
    load2 = 1'b0;
    cnt = 0;
    b = (which == 4) ? busy4 : busy2;
    while (b && cnt < 40) begin
      cnt++;
      if (cnt == relo_at) begin
        data = 8'd45;
        signed_mode = 1'b0;
        if (which == 4) load4 = 1'b1; else load2 = 1'b1;
      end
      @(negedge clk);
      load4 = 1'b0;
      load2 = 1'b0;
      b = (which == 4) ? busy4 : busy2;
    end
    check({tag, "_busy_len"}, cnt, 32'd9);
    if (which == 4) e = sb4.pop_front();
    else            e = sb2.pop_front();
    check({tag, "_ovf"}, {31'd0, (which == 4) ? ovf4 : ovf2}, {31'd0, e.ovf});
    @(negedge clk);
    capture(which, got);
    mask = (which == 4) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    check({tag, "_disp"}, got & mask, e.disp & mask);
    check({tag, "_idle"}, {31'd0, (which == 4) ? busy4 : busy2}, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [3:0]  exp_an;

    repeat (2) @(negedge clk);

    // Reset state and first scan rotation.
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_ovf4",  {31'd0, ovf4},  32'd0);
    check("rst_an2",   {30'd0, an2},   32'h2);
    check("rst_seg2",  {24'd0, seg2},  32'hC0);
    for (int k = 0; k < 20; k++) begin
      if (k == 0) reset = 1'b0;
      exp_an = ~(4'd1 << ((k / 4) % 4));
      check("scan_an", {28'd0, an4}, {28'd0, exp_an});
      check("scan_seg", {24'd0, seg4}, ((k / 4) % 4 == 0) ? 32'hC0 : 32'hFF);
      @(negedge clk);
    end

    run_load(4, 8'd123, 1'b0, -1, "u123");
    run_load(4, 8'h80,  1'b1, -1, "s_m128");
    run_load(4, 8'hFB,  1'b1, -1, "s_m5");
    run_load(4, 8'h80,  1'b0, -1, "u128");
    run_load(4, 8'd0,   1'b0, -1, "zero");
    run_load(4, 8'hFF,  1'b1, -1, "s_m1");
    run_load(4, 8'hFF,  1'b0, -1, "u255");
    run_load(2, 8'd200, 1'b0, -1, "n2_u200");
    run_load(2, 8'hF6,  1'b1, -1, "n2_s_m10");
    run_load(2, 8'd7,   1'b0, -1, "n2_u7");
    run_load(2, 8'hF7,  1'b1, -1, "n2_s_m9");
    run_load(2, 8'd99,  1'b0, -1, "n2_u99");
    run_load(4, 8'd123, 1'b0, 3,  "relo");

    // Reset part-way through a conversion.
    @(negedge clk);
    data = 8'd99;
    signed_mode = 1'b0;
    load4 = 1'b1;
    @(negedge clk);
    load4 = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", {31'd0, busy4}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy4}, 32'd0);
    check("abort_an",   {28'd0, an4},   32'hE);
    check("abort_seg",  {24'd0, seg4},  32'hC0);
    check("abort_ovf",  {31'd0, ovf4},  32'd0);
    reset = 1'b0;
    @(negedge clk);
    capture(4, got);
    check("abort_disp", got, 32'hFFFF_FFC0);
    check("abort_idle", {31'd0, busy4}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_seven_seg_driver.md
MULTI_SEVEN_SEG_DRIVER -- requirements
Module: multi_seven_seg_driver

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digits (2..8).
REQ-002 The module SHALL have parameter DATA_W, default 8, giving the input value width (4..16).
REQ-003 The module SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles per digit in the scan (>=2).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port data, input, DATA_W bits: the value to display.
REQ-007 The module SHALL have port signed_mode, input, 1 bit: 1 means data is two's complement, 0 means unsigned; it is sampled with load.
REQ-008 The module SHALL have port load, input, 1 bit: a one-cycle request to convert and display data.
REQ-009 The module SHALL have port seg, output, 8 bits: active-low segments, bit7=dp and bits6..0=g..a.
REQ-010 The module SHALL have port an, output, NUM_DIGITS bits: active-low digit enables, bit0 = rightmost digit.
REQ-011 The module SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-012 The module SHALL have port ovf, output, 1 bit: high when the last converted value did not fit in NUM_DIGITS.

Function
REQ-013 Segment patterns SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF, blank=FF (hex); dp always off.
REQ-014 The conversion FSM SHALL have exactly three states: IDLE, CONVERT and FORMAT.
REQ-015 In IDLE, load=1 SHALL capture signed_mode and the magnitude of data, clear the iteration counter and move to CONVERT.
REQ-016 The captured magnitude SHALL be |data| when signed_mode=1 and data[DATA_W-1]=1, and data otherwise.
REQ-017 The most-negative input SHALL convert correctly; for example, -128 at DATA_W=8 gives magnitude 128 held unsigned in DATA_W bits.
REQ-018 CONVERT SHALL perform one shift-add-3 (double-dabble) iteration per cycle for exactly DATA_W cycles, then move to FORMAT.
REQ-019 FORMAT SHALL write all NUM_DIGITS display registers and ovf in one cycle, then return to IDLE.
REQ-020 The first displayed digit SHALL be updated exactly DATA_W+2 cycles after the load edge.
REQ-021 busy SHALL be 1 in CONVERT and FORMAT and 0 in IDLE.
REQ-022 load asserted while busy=1 SHALL be ignored, with no queuing.
REQ-023 The display SHALL blank leading zeros; a value of 0 SHALL show a single "0" in digit 0.
REQ-024 A negative value SHALL place a dash in the digit immediately left of the most significant nonzero digit.
REQ-025 If the required digit count (including the sign) exceeds NUM_DIGITS, every digit SHALL show a dash and ovf SHALL be 1; otherwise ovf SHALL be 0.
REQ-026 Display registers SHALL change only in FORMAT, so the display never shows a partial conversion.
REQ-027 A prescaler SHALL count 0..SCAN_DIV-1; at its terminal count the digit index SHALL advance by one and wrap from NUM_DIGITS-1 to 0.
REQ-028 an SHALL be all ones except a 0 at the current index, and seg SHALL show that index's display register.
REQ-029 an and seg SHALL be registered, changing together on the cycle after the terminal count.
REQ-030 Scanning SHALL run continuously and be independent of busy, load and the FSM state.

Reset
REQ-031 reset=1 SHALL take priority over load and override any state.
REQ-032 Reset SHALL set the FSM to IDLE, the prescaler to 0, the digit index to 0 and busy to 0.
REQ-033 Reset SHALL set ovf to 0, display register 0 to C0 (a "0") and all other display registers to FF.
REQ-034 The outputs on the cycle after reset SHALL be an = ~1 (0b...1110) and seg = C0.
REQ-035 Reset during CONVERT or FORMAT SHALL abort the conversion with no display update.

Verification (NUM_DIGITS=4, DATA_W=8, SCAN_DIV=4 unless stated)
REQ-036 Scan after reset: an SHALL follow 1110, 1101, 1011, 0111, 1110 with each value held 4 cycles; seg SHALL be C0, FF, FF, FF.
REQ-037 load with data=123 and signed_mode=0: busy SHALL be high for 9 cycles; afterwards digits 3..0 SHALL be FF, F9, A4, B0 and ovf=0.
REQ-038 Signed -128 SHALL give digits 3..0 = BF, F9, A4, 80; signed -5 SHALL give FF, FF, BF, 92; unsigned 0x80 SHALL give FF, F9, A4, 80.
REQ-039 With NUM_DIGITS=2, unsigned 200 and signed -10 SHALL each give ovf=1 with both digits BF; a following load of 7 SHALL give ovf=0 and digits FF, F8.
REQ-040 A second load 3 cycles into the conversion of 123 SHALL be ignored, so the final display is 123.
REQ-041 Reset asserted at CONVERT cycle 5 SHALL return the reset display (C0 in digit 0) and busy=0 on the next cycle.
